ram_dump_engine: RTL
====================

// Module: ram_dump_engine
// PURPOSE
//  Master for the byte-wide CPU work-RAM port (address/write/data/q, 1-cycle registered read).
//  Loads RAM from, or dumps RAM to, the host bridge as 32-bit little-endian words (NVRAM / high-score save-restore).
//  Requests a CPU hold and waits for the acknowledge before it touches the RAM port.
//  The top-level mux hands the RAM port to this block while cpu_hold_ack=1.
// PARAMETERS
//  ADDR_W  11  RAM address width; depth = 2**ADDR_W bytes
//  LEN_W   12  byte-count width (ADDR_W+1); allows a full-RAM transfer
// PORTS
//  clk           in   1       system clock; all logic on rising edge
//  reset_n       in   1       asynchronous active-low reset
//  cmd_valid     in   1       command request
//  cmd_ready     out  1       high only in IDLE; command accepted on valid&ready
//  cmd_load      in   1       1 = host->RAM (load), 0 = RAM->host (dump)
//  cmd_base      in   ADDR_W  first RAM byte address
//  cmd_len       in   LEN_W   byte count, 1..2**ADDR_W (0 = no-op)
//  wdata_valid   in   1       load data word valid
//  wdata_ready   out  1       load data word accepted on valid&ready
//  wdata         in   32      load word; byte0 = [7:0] goes to the lowest address
//  rdata_valid   out  1       dump data word valid
//  rdata_ready   in   1       host accepts dump word
//  rdata         out  32      dump word; same byte order as wdata
//  done          out  1       one-cycle pulse at end of command
//  cpu_hold      out  1       request CPU halt / RAM port ownership
//  cpu_hold_ack  in   1       CPU halted, RAM port owned by this block
//  ram_address   out  ADDR_W  RAM address
//  ram_write     out  1       RAM write strobe
//  ram_data      out  8       RAM write data
//  ram_q         in   8       RAM read data, valid one clk after ram_address
// BEHAVIOUR
//  Reset: state IDLE. cmd_ready=1. wdata_ready, rdata_valid, done, cpu_hold and ram_write all 0.
//   rdata=0, ram_address=0, ram_data=0.
//  FSM: IDLE -> HOLD on accepted cmd with len!=0. len==0 -> done pulse next cycle, stays IDLE, cpu_hold never asserted.
//  HOLD: cpu_hold=1; wait for cpu_hold_ack=1, then go to LD_WAIT (load) or RD_ADDR (dump).
//   cpu_hold stays 1 through the command and drops on the cycle done pulses.
//  LD_WAIT: wdata_ready=1; on handshake latch the word, then go to LD_WR.
//  LD_WR: one byte per cycle, bytes 0..3 in order. ram_write=1, ram_address=addr, ram_data=byte.
//   addr and remaining count update each byte.
//   Leaving LD_WR: remaining=0 -> DONE; 4 bytes written -> LD_WAIT.
//   Surplus bytes of the last word are discarded and never written.
//  RD_ADDR: drive ram_address=addr, one byte per cycle, up to 4 bytes or the remaining count.
//   Each byte is captured from ram_q the cycle after its address (pipelined, no bubbles).
//   Capture goes into byte lane k of an assembly register. The last capture goes to RD_OUT.
//  RD_OUT: rdata_valid=1, rdata held stable until rdata_ready.
//   Unused high lanes of the final partial word = 0.
//   On handshake: remaining=0 -> DONE, else -> RD_ADDR.
//  DONE: done=1 for one cycle, cpu_hold=0, go to IDLE.
//  Address arithmetic: addr increments modulo 2**ADDR_W; base+len past the top wraps to 0.
//   remaining is LEN_W bits and decrements by 1 per byte.
//  ram_write is 1 only in LD_WR; never asserted in a dump or while cpu_hold_ack=0.
//  cpu_hold_ack deasserting mid-command: freeze (no RAM strobes, counters held) until it returns.
//   Host-side handshakes are unaffected.
//  cmd_* inputs are ignored outside IDLE. valid/data outputs hold while the host stalls.
//  Async reset mid-command: abort immediately to the reset values above; no done pulse.
// STRUCTURE
//  Shared package: state enum (IDLE,HOLD,LD_WAIT,LD_WR,RD_ADDR,RD_OUT,DONE), BYTES_PER_WORD=4.
//  Single module; no sub-module (byte-lane counter and assembly register are inline).
// TESTING
//  Load base=0x010 len=8, words 0x44332211,0x88776655 -> RAM[0x010..0x017]=11..88.
//   8 ram_write pulses, done once.
//  Dump base=0x010 len=6 -> rdata 0x44332211 then 0x00006655; done after the 2nd handshake.
//  Load base=0x7FE len=4 word 0xDDCCBBAA -> RAM[0x7FE]=AA, [0x7FF]=BB, [0x000]=CC, [0x001]=DD (wrap).
//  Dump with rdata_ready low 10 cycles -> rdata/rdata_valid stable; no extra RAM reads or address advance.
//  cpu_hold_ack delayed 5 cycles, then dropped 3 cycles mid-load -> no ram_write while ack=0.
//   RAM contents still exact.
//  len=0 -> done 1 cycle later, cpu_hold stays 0.
//   reset_n low mid-dump -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ram_dump_engine_pkg.sv
// Shared types and constants for the RAM dump/load engine.
package ram_dump_engine_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StLdWait,
        StLdWr,
        StRdAddr,
        StRdOut,
        StDone
    } state_e;

    // Byte lane `lane` of a little-endian host word.
    function automatic logic [7:0] get_lane(input logic [WORD_W-1:0] word,
                                            input logic [LANE_W-1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ram_dump_engine_if.sv
// Host command/data handshakes, CPU hold handshake and byte-wide work-RAM port.
interface ram_dump_engine_if
    import ram_dump_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned LEN_W  = 12
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_load;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [WORD_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [WORD_W-1:0] rdata;
    logic              done;
    logic              cpu_hold;
    logic              cpu_hold_ack;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_write;
    logic [7:0]        ram_data;
    logic [7:0]        ram_q;

    // Engine side.
    modport master (
        input  cmd_valid, cmd_load, cmd_base, cmd_len, wdata_valid, wdata, rdata_ready,
               cpu_hold_ack, ram_q,
        output cmd_ready, wdata_ready, rdata_valid, rdata, done, cpu_hold, ram_address,
               ram_write, ram_data
    );

    // Host bridge / CPU / RAM side.
    modport slave (
        output cmd_valid, cmd_load, cmd_base, cmd_len, wdata_valid, wdata, rdata_ready,
               cpu_hold_ack, ram_q,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, done, cpu_hold, ram_address,
               ram_write, ram_data
    );

endinterface

// File: rtl/ram_dump_engine.sv
// Loads work-RAM from, or dumps it to, the host as 32-bit little-endian words while the CPU
// is held off the RAM port.
module ram_dump_engine
    import ram_dump_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_dump_engine_if.master bus
);

    state_e            state_q, state_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    // All reads of the current dump word have been issued; waiting for the last capture.
    logic              issue_done_q, issue_done_d;
    // A read was issued last cycle; ram_q holds its byte now.
    logic              cap_pend_q, cap_pend_d;
    logic [LANE_W-1:0] cap_lane_q, cap_lane_d;
    logic              cap_last_q, cap_last_d;

    logic last_byte;
    logic lane_full;

    assign last_byte = (rem_q == LEN_W'(1));
    assign lane_full = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    // Outputs are decoded straight from state so they hold while the host stalls.
    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.wdata_ready = (state_q == StLdWait);
    assign bus.rdata_valid = (state_q == StRdOut);
    assign bus.done        = (state_q == StDone);
    assign bus.cpu_hold    = state_q inside {StHold, StLdWait, StLdWr, StRdAddr, StRdOut};
    assign bus.ram_write   = (state_q == StLdWr) && bus.cpu_hold_ack;
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = get_lane(word_q, lane_q);
    assign bus.rdata       = asm_q;

    // Next-state logic: command decode, byte sequencing and read-capture pipeline.
    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        lane_d       = lane_q;
        word_d       = word_q;
        asm_d        = asm_q;
        issue_done_d = issue_done_q;
        cap_pend_d   = 1'b0;
        cap_lane_d   = cap_lane_q;
        cap_last_d   = cap_last_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    load_d       = bus.cmd_load;
                    addr_d       = bus.cmd_base;
                    rem_d        = bus.cmd_len;
                    lane_d       = '0;
                    asm_d        = '0;
                    issue_done_d = 1'b0;
                    state_d      = (bus.cmd_len == '0) ? StDone : StHold;
                end
            end
            StHold: begin
                if (bus.cpu_hold_ack) begin
                    state_d = load_q ? StLdWait : StRdAddr;
                end
            end
            StLdWait: begin
                if (bus.wdata_valid) begin
                    word_d  = bus.wdata;
                    lane_d  = '0;
                    state_d = StLdWr;
                end
            end
            StLdWr: begin
                // Losing the ack freezes the byte sequence in place.
                if (bus.cpu_hold_ack) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    lane_d = lane_q + LANE_W'(1);
                    if (last_byte) begin
                        state_d = StDone;
                    end else if (lane_full) begin
                        state_d = StLdWait;
                    end
                end
            end
            StRdAddr: begin
                // The byte addressed last cycle arrives now, regardless of the ack.
                if (cap_pend_q) begin
                    asm_d[{cap_lane_q, 3'b000} +: 8] = bus.ram_q;
                    if (cap_last_q) begin
                        state_d = StRdOut;
                    end
                end
                if (bus.cpu_hold_ack && !issue_done_q) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    rem_d        = rem_q - LEN_W'(1);
                    lane_d       = lane_q + LANE_W'(1);
                    cap_pend_d   = 1'b1;
                    cap_lane_d   = lane_q;
                    cap_last_d   = lane_full || last_byte;
                    issue_done_d = lane_full || last_byte;
                end
            end
            StRdOut: begin
                if (bus.rdata_ready) begin
                    asm_d        = '0;
                    lane_d       = '0;
                    issue_done_d = 1'b0;
                    state_d      = (rem_q == '0) ? StDone : StRdAddr;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any command without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            load_q       <= 1'b0;
            addr_q       <= '0;
            rem_q        <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            asm_q        <= '0;
            issue_done_q <= 1'b0;
            cap_pend_q   <= 1'b0;
            cap_lane_q   <= '0;
            cap_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            asm_q        <= asm_d;
            issue_done_q <= issue_done_d;
            cap_pend_q   <= cap_pend_d;
            cap_lane_q   <= cap_lane_d;
            cap_last_q   <= cap_last_d;
        end
    end

endmodule
